// File: rtl/pipe_stage_reg.sv
// ----------------------------------------------------------------------------
// pipe_stage_reg
//
// Valid/ready handshaked pipeline stage register that sits between two
// adjacent stages of the RISC-V core (IF/ID, ID/EX, ...). It supports
// downstream stall, a synchronous flush that kills every held beat, and a
// configurable payload width.
//
// Build option (macro PIPE_SKID_EN):
//   defined   : 2-entry stage (main + skid register). in_ready is a flop
//               output, so there is no combinational path from out_ready
//               to in_ready. occupancy ranges 0..2.
//   undefined : single-entry stage. in_ready = !out_valid | out_ready
//               (combinational from out_ready). occupancy ranges 0..1 and
//               bit 1 is tied to 0. No skid register is built.
//
// Parameters:
//   DATA_W     payload width (default packs {pc[31:0], instr[31:0]})
//   FLUSH_VAL  payload loaded at reset and on flush (e.g. a NOP)
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   flush      in   synchronous kill of all held beats
//   in_valid   in   upstream beat valid
//   in_ready   out  stage can accept a beat this cycle
//   in_data    in   upstream payload
//   out_valid  out  stage holds a valid beat
//   out_ready  in   downstream accepts the beat this cycle
//   out_data   out  payload of the oldest held beat (main register)
//   occupancy  out  number of held beats
// ----------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int                DATA_W    = 64,
    parameter logic [DATA_W-1:0] FLUSH_VAL = {DATA_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

`ifdef PIPE_SKID_EN

    // State value doubles as the occupancy count.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t              r_state;
    logic [DATA_W-1:0]   r_main;
    logic [DATA_W-1:0]   r_skid;
    logic                r_in_ready;

    logic                w_in_fire;
    logic                w_out_fire;

    assign w_in_fire  = in_valid & r_in_ready;
    assign w_out_fire = (r_state != S_EMPTY) & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_EMPTY;
            r_main     <= FLUSH_VAL;
            r_skid     <= FLUSH_VAL;
            r_in_ready <= 1'b1;
        end else if (flush) begin
            // Any beat offered this cycle is dropped; an output fire this
            // cycle has already been taken by the downstream stage.
            r_state    <= S_EMPTY;
            r_main     <= FLUSH_VAL;
            r_skid     <= FLUSH_VAL;
            r_in_ready <= 1'b1;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_in_fire) begin
                        r_state <= S_ONE;
                        r_main  <= in_data;
                    end
                    r_in_ready <= 1'b1;
                end
                S_ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        r_main     <= in_data;
                        r_in_ready <= 1'b1;
                    end else if (w_in_fire) begin
                        // Downstream stalled: park the new beat in skid.
                        r_state    <= S_FULL;
                        r_skid     <= in_data;
                        r_in_ready <= 1'b0;
                    end else if (w_out_fire) begin
                        r_state    <= S_EMPTY;
                        r_in_ready <= 1'b1;
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                S_FULL: begin
                    // in_ready is low here, so no input fire is possible.
                    if (w_out_fire) begin
                        r_state    <= S_ONE;
                        r_main     <= r_skid;
                        r_in_ready <= 1'b1;
                    end else begin
                        r_in_ready <= 1'b0;
                    end
                end
                default: begin
                    // Unreachable encoding: recover to a clean empty stage.
                    r_state    <= S_EMPTY;
                    r_main     <= FLUSH_VAL;
                    r_skid     <= FLUSH_VAL;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = (r_state != S_EMPTY);
    assign out_data  = r_main;
    assign occupancy = r_state;

`else

    logic                r_valid;
    logic [DATA_W-1:0]   r_main;

    logic                w_in_ready;
    logic                w_in_fire;
    logic                w_out_fire;

    // Single entry: a new beat is only accepted if the held one leaves
    // in the same cycle (or the stage is empty).
    assign w_in_ready = ~r_valid | out_ready;
    assign w_in_fire  = in_valid & w_in_ready;
    assign w_out_fire = r_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_main  <= FLUSH_VAL;
        end else if (flush) begin
            r_valid <= 1'b0;
            r_main  <= FLUSH_VAL;
        end else if (w_in_fire) begin
            r_valid <= 1'b1;
            r_main  <= in_data;
        end else if (w_out_fire) begin
            r_valid <= 1'b0;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_valid;
    assign out_data  = r_main;
    assign occupancy = {1'b0, r_valid};

`endif

endmodule
